// File: rtl/vgpr_operand_collector.sv
// Operand collector in front of the 3R/1W VGPR bank. It issues up to three reads
// (src0 may be a 64-bit pair), snoops the write port for forwarding, and hands operands to issue.
module vgpr_operand_collector #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_src0_addr,
    input  logic [ADDR_W-1:0]   req_src1_addr,
    input  logic [ADDR_W-1:0]   req_src2_addr,
    input  logic [2:0]          req_src_mask,
    input  logic                req_src0_dbl,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [ADDR_W-1:0]   rd0_addr,
    output logic [ADDR_W-1:0]   rd1_addr,
    output logic [ADDR_W-1:0]   rd2_addr,
    input  logic [DATA_W-1:0]   rd0_data,
    input  logic [DATA_W-1:0]   rd1_data,
    input  logic [DATA_W-1:0]   rd2_data,
    input  logic [ADDR_W-1:0]   wr0_addr,
    input  logic [3:0]          wr0_en,
    input  logic [DATA_W-1:0]   wr0_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_src0,
    output logic [DATA_W-1:0]   out_src1,
    output logic [DATA_W-1:0]   out_src2,
    output logic [TAG_W-1:0]    out_tag
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPT    = 3'd2,
        CAPT_HI = 3'd3,
        VALID   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // A snooped write hits a read port when it is real, the port is in use and addresses match.
    function automatic logic wr_hit(input logic [3:0]        en,
                                    input logic [ADDR_W-1:0] waddr,
                                    input logic [ADDR_W-1:0] raddr,
                                    input logic              used);
        return (en != 4'b0000) && (waddr == raddr) && used;
    endfunction

    state_t              state_r, state_nxt_s;
    logic                req_ready_r, out_valid_r;
    logic [2:0]          mask_r;
    logic                dbl_r;
    logic [ADDR_W-1:0]   rd_addr_r [3];
    logic [DATA_W-1:0]   rd_data_s [3];
    logic [2:0]          fwd_r;
    logic [DATA_W-1:0]   fwd_data_r [3];
    logic [2:0]          hit_s;
    logic [DATA_W-1:0]   lo_s [3];
    logic [2*DATA_W-1:0] out_src0_r;
    logic [DATA_W-1:0]   out_src1_r, out_src2_r;
    logic [TAG_W-1:0]    out_tag_r;

    assign rd_data_s[0] = rd0_data;
    assign rd_data_s[1] = rd1_data;
    assign rd_data_s[2] = rd2_data;

    assign req_ready = req_ready_r;
    assign out_valid = out_valid_r;
    assign rd0_addr  = rd_addr_r[0];
    assign rd1_addr  = rd_addr_r[1];
    assign rd2_addr  = rd_addr_r[2];
    assign out_src0  = out_src0_r;
    assign out_src1  = out_src1_r;
    assign out_src2  = out_src2_r;
    assign out_tag   = out_tag_r;

    // Per-port write hit and the low dword each port would capture this cycle.
    always_comb begin
        hit_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            hit_s[k] = wr_hit(wr0_en, wr0_addr, rd_addr_r[k], mask_r[k]);
            if (!mask_r[k]) begin
                lo_s[k] = DATA_ZERO;
            end else if (fwd_r[k]) begin
                lo_s[k] = fwd_data_r[k];
            end else begin
                lo_s[k] = rd_data_s[k];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = CAPT;
            CAPT: begin
                if (dbl_r) begin
                    state_nxt_s = CAPT_HI;
                end else begin
                    state_nxt_s = VALID;
                end
            end
            CAPT_HI: state_nxt_s = VALID;
            VALID: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = VALID;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == VALID);
        end
    end

    // Datapath: address issue, forwarding capture and operand assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_r     <= 3'b000;
            dbl_r      <= 1'b0;
            fwd_r      <= 3'b000;
            out_src0_r <= {(2*DATA_W){1'b0}};
            out_src1_r <= DATA_ZERO;
            out_src2_r <= DATA_ZERO;
            out_tag_r  <= {TAG_W{1'b0}};
            for (int k = 0; k < 3; k++) begin
                rd_addr_r[k]  <= ADDR_ZERO;
                fwd_data_r[k] <= DATA_ZERO;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        mask_r       <= req_src_mask;
                        // a pair is only fetched when src0 is actually used
                        dbl_r        <= req_src0_dbl & req_src_mask[0];
                        out_tag_r    <= req_tag;
                        fwd_r        <= 3'b000;
                        rd_addr_r[0] <= req_src_mask[0] ? req_src0_addr : ADDR_ZERO;
                        rd_addr_r[1] <= req_src_mask[1] ? req_src1_addr : ADDR_ZERO;
                        rd_addr_r[2] <= req_src_mask[2] ? req_src2_addr : ADDR_ZERO;
                    end
                end
                ISSUE: begin
                    for (int k = 0; k < 3; k++) begin
                        if (hit_s[k]) begin
                            fwd_r[k]      <= 1'b1;
                            fwd_data_r[k] <= wr0_data;
                        end
                    end
                    if (dbl_r) begin
                        rd_addr_r[0] <= rd_addr_r[0] + ADDR_ONE;
                    end
                end
                CAPT: begin
                    out_src0_r[DATA_W-1:0] <= lo_s[0];
                    out_src1_r             <= lo_s[1];
                    out_src2_r             <= lo_s[2];
                    if (dbl_r) begin
                        // port 0 flag is reused for the high dword, now addressed at base+1
                        fwd_r[0]      <= hit_s[0];
                        fwd_data_r[0] <= wr0_data;
                    end else begin
                        out_src0_r[2*DATA_W-1:DATA_W] <= DATA_ZERO;
                    end
                end
                CAPT_HI: begin
                    out_src0_r[2*DATA_W-1:DATA_W] <= fwd_r[0] ? fwd_data_r[0] : rd_data_s[0];
                end
                VALID: begin
                    out_tag_r <= out_tag_r;
                end
                default: begin
                    fwd_r <= 3'b000;
                end
            endcase
        end
    end

endmodule
